// File: rtl/icache_arb_pkg.sv
// icache_arb_pkg
// Shared definitions for the instruction-cache refill arbiter:
//   - arb_state_e : FSM state encoding (IDLE=0, BUSY=1, DONE=2)
//   - clog2()     : width helper used to size the grant index
// No ports; imported by icache_rr_pick and icache_mem_arbiter.
package icache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // Ceiling log2, usable in parameter context.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

  // Grant index width for a given requester count, never narrower than 1 bit.
  function automatic int grant_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/icache_rr_pick.sv
// icache_rr_pick
// Combinational rotate-priority search. Starting at rr_ptr_i and wrapping
// modulo NUM_REQ, returns the first requester whose bit is set.
// Ports:
//   req_i    [NUM_REQ-1:0] request vector
//   rr_ptr_i [GW-1:0]      index where the search starts
//   any_o                  1 when at least one request bit is set
//   grant_o  [GW-1:0]      selected requester index (0 when any_o is 0)
module icache_rr_pick
  import icache_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GW      = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      rr_ptr_i,
  output logic               any_o,
  output logic [GW-1:0]      grant_o
);

  // Walk the rotated order from the far end towards the pointer so that the
  // candidate closest to rr_ptr_i is the last one written and therefore wins.
  always_comb begin
    logic [GW-1:0] idx;
    any_o   = |req_i;
    grant_o = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = GW'((int'(rr_ptr_i) + k) % NUM_REQ);
      if (req_i[idx]) begin
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/icache_mem_arbiter.sv
// icache_mem_arbiter
// Round-robin arbiter that funnels instruction-cache line refills from
// NUM_REQ requesters onto a single memory port, one transaction at a time.
// Optional build macro: ICACHE_ARB_STATS_EN adds grant/wait statistics ports.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req_valid[NUM_REQ]   per-requester refill request (held until req_ready)
//   req_addr[32*NUM_REQ] per-requester address, slice i = [32*i +: 32]
//   req_ready[NUM_REQ]   one-cycle completion pulse to the granted requester
//   req_rdata[LINE]      refill line, broadcast, valid while req_ready != 0
//   mem_req_valid        memory request, held until mem_req_ready
//   mem_req_ready        memory completion, mem_req_rdata valid same cycle
//   mem_req_addr[32]     granted address with low ALIGN_BITS forced to zero
//   mem_req_rdata[LINE]  memory line data
//   stat_grants[32*NUM_REQ], stat_wait[32]  (only with ICACHE_ARB_STATS_EN)
module icache_mem_arbiter
  import icache_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int LINE_WIDTH = 64,
  parameter int ALIGN_BITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [LINE_WIDTH-1:0]   req_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [31:0]             mem_req_addr,
  input  logic [LINE_WIDTH-1:0]   mem_req_rdata
`ifdef ICACHE_ARB_STATS_EN
  ,
  output logic [32*NUM_REQ-1:0]   stat_grants,
  output logic [31:0]             stat_wait
`endif
);

  localparam int          GW         = grant_width(NUM_REQ);
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ALIGN_BITS) - 32'd1);

  arb_state_e             state_q;
  logic [GW-1:0]          grant_q;
  logic [GW-1:0]          rr_ptr_q;
  logic [GW-1:0]          rr_ptr_d;
  logic                   mem_req_valid_q;
  logic [31:0]            mem_req_addr_q;
  logic [31:0]            mem_req_addr_d;
  logic [NUM_REQ-1:0]     req_ready_q;
  logic [LINE_WIDTH-1:0]  req_rdata_q;

  logic                   pick_any;
  logic [GW-1:0]          pick_grant;
  logic [NUM_REQ-1:0]     pick_oh;
  logic [NUM_REQ-1:0]     grant_oh;

  icache_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_pick (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .any_o    (pick_any),
    .grant_o  (pick_grant)
  );

  assign pick_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_grant;
  assign grant_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

  // Next pointer and aligned address for the candidate picked this cycle;
  // only consumed when an IDLE cycle actually grants.
  always_comb begin
    rr_ptr_d       = (pick_grant == GW'(NUM_REQ - 1)) ? '0 : pick_grant + GW'(1);
    mem_req_addr_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant == GW'(i)) begin
        mem_req_addr_d = req_addr[32*i +: 32] & ALIGN_MASK;
      end
    end
  end

  // Transaction FSM with registered outputs. The completion pulse is set on
  // the BUSY->DONE edge so it is visible exactly during the DONE cycle, and is
  // gated by the requester still asking (an abandoned request gets no pulse).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      rr_ptr_q        <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      req_ready_q     <= '0;
      req_rdata_q     <= '0;
    end else begin
      req_ready_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q         <= BUSY;
            grant_q         <= pick_grant;
            rr_ptr_q        <= rr_ptr_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_valid_q <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_req_ready) begin
            state_q         <= DONE;
            mem_req_valid_q <= 1'b0;
            req_rdata_q     <= mem_req_rdata;
            req_ready_q     <= grant_oh & req_valid;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign req_rdata     = req_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;

`ifdef ICACHE_ARB_STATS_EN
  logic [32*NUM_REQ-1:0] stat_grants_q;
  logic [31:0]           stat_wait_q;
  logic [NUM_REQ-1:0]    served_oh;

  // Requester currently owning the port: the fresh pick in IDLE, the latched
  // grant while a transaction is in flight or completing.
  always_comb begin
    served_oh = '0;
    if (state_q == IDLE) begin
      served_oh = pick_any ? pick_oh : '0;
    end else begin
      served_oh = grant_oh;
    end
  end

  // Grants are counted on completion (aborts included); a wait cycle is any
  // cycle where some asking requester is not the one being served.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants_q <= '0;
      stat_wait_q   <= '0;
    end else begin
      if (|(req_valid & ~served_oh)) begin
        stat_wait_q <= stat_wait_q + 32'd1;
      end
      if ((state_q == BUSY) && mem_req_ready) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == GW'(i)) begin
            stat_grants_q[32*i +: 32] <= stat_grants_q[32*i +: 32] + 32'd1;
          end
        end
      end
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_wait   = stat_wait_q;
`endif

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// tb_icache_mem_arbiter
// Directed plus randomized bench for icache_mem_arbiter. The reference model
// is transaction level: a round-robin pointer, per-requester grant counts and
// a wait counter, all updated from the requester-visible rules.
// Define ICACHE_ARB_STATS_EN for both DUT and bench to cover the statistics.
module tb_icache_mem_arbiter;

  localparam int N  = 2;
  localparam int LW = 64;
  localparam int AB = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [32*N-1:0]   req_addr;
  logic [N-1:0]      req_ready;
  logic [LW-1:0]     req_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [31:0]       mem_req_addr;
  logic [LW-1:0]     mem_req_rdata;
`ifdef ICACHE_ARB_STATS_EN
  logic [32*N-1:0]   stat_grants;
  logic [31:0]       stat_wait;
`endif

  icache_mem_arbiter #(
    .NUM_REQ    (N),
    .LINE_WIDTH (LW),
    .ALIGN_BITS (AB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .req_rdata     (req_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_rdata (mem_req_rdata)
`ifdef ICACHE_ARB_STATS_EN
    ,
    .stat_grants   (stat_grants),
    .stat_wait     (stat_wait)
`endif
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  int           rrPtr = 0;
  int           curG = -1;
  int           waitModel = 0;
  int           grantsModel [N];
  logic [N-1:0] lastPulse;

  // Single comparison point: counts, asserts, reports.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] oneHot(input int g);
    return (g < 0) ? '0 : (N'(1) << g);
  endfunction

  // Round-robin rule: first asking requester at or after the pointer, wrapping.
  function automatic int pickModel(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(rrPtr + k) % N]) return (rrPtr + k) % N;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] v, input logic [32*N-1:0] a);
    req_valid = v;
    req_addr  = a;
  endtask

  // Advance one clock; the model accounts for the cycle that is ending.
  task automatic tick();
    if (reset) begin
      waitModel = 0;
      rrPtr     = 0;
      foreach (grantsModel[i]) grantsModel[i] = 0;
    end else if ((req_valid & ~oneHot(curG)) != '0) begin
      waitModel++;
    end
    @(posedge clk);
    #1;
  endtask

  // One complete transaction, starting in an IDLE cycle with req_valid != 0.
  task automatic serve(input int memDelay, input logic [LW-1:0] rdata, input bit abortIt,
                       input logic [N-1:0] doneNext, input bit churn);
    int           g;
    logic [31:0]  expAddr;
    logic [N-1:0] expReady;
    g = pickModel(req_valid);
    if (g < 0) g = 0;
    rrPtr   = (g + 1) % N;
    expAddr = req_addr[32*g +: 32] & ~((32'd1 << AB) - 32'd1);
    curG    = g;
    mem_req_ready = churn ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    checkOutput("busy_valid", 128'(mem_req_valid), 128'(1'b1));
    checkOutput("busy_addr", 128'(mem_req_addr), 128'(expAddr));
    checkOutput("busy_ready", 128'(req_ready), 128'(0));
    if (abortIt) req_valid[g] = 1'b0;
    mem_req_ready = 1'b0;
    for (int d = 0; d < memDelay; d++) begin
      if (churn) req_valid = (req_valid & oneHot(g)) | (N'($urandom) & ~oneHot(g));
      tick();
      checkOutput("hold_valid", 128'(mem_req_valid), 128'(1'b1));
      checkOutput("hold_addr", 128'(mem_req_addr), 128'(expAddr));
    end
    mem_req_ready = 1'b1;
    mem_req_rdata = rdata;
    tick();
    grantsModel[g]++;
    expReady  = abortIt ? '0 : oneHot(g);
    lastPulse = req_ready;
    checkOutput("done_valid", 128'(mem_req_valid), 128'(1'b0));
    checkOutput("done_ready", 128'(req_ready), 128'(expReady));
    checkOutput("done_rdata", 128'(req_rdata), 128'(rdata));
    req_valid     = (req_valid & ~oneHot(g)) | doneNext;
    mem_req_ready = churn ? 1'($urandom_range(0, 1)) : 1'b0;
    mem_req_rdata = {$urandom, $urandom};
    tick();
    curG = -1;
    checkOutput("post_ready", 128'(req_ready), 128'(0));
    checkOutput("post_valid", 128'(mem_req_valid), 128'(1'b0));
    checkOutput("post_rdata", 128'(req_rdata), 128'(rdata));
  endtask

  task automatic checkStats(input string tag);
`ifdef ICACHE_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      checkOutput({tag, "_grants"}, 128'(stat_grants[32*i +: 32]), 128'(grantsModel[i]));
    end
    checkOutput({tag, "_wait"}, 128'(stat_wait), 128'(waitModel));
`else
    if (tag.len() < 0) $display("[TB] %s", tag);
`endif
  endtask

  initial begin
    int g;
    int guard;
    foreach (grantsModel[i]) grantsModel[i] = 0;
    reset         = 1'b1;
    mem_req_ready = 1'b0;
    mem_req_rdata = '0;
    applyStimulus('0, '0);
    tick();
    tick();
    checkOutput("rst_valid", 128'(mem_req_valid), 128'(0));
    checkOutput("rst_addr", 128'(mem_req_addr), 128'(0));
    checkOutput("rst_ready", 128'(req_ready), 128'(0));
    checkOutput("rst_rdata", 128'(req_rdata), 128'(0));
    checkStats("rst");
    reset = 1'b0;

    // Single refill with an unaligned address and three wait cycles.
    applyStimulus(2'b01, {32'h0000_5678, 32'h0000_1234});
    serve(3, 64'hDEAD_BEEF_0123_4567, 1'b0, 2'b00, 1'b0);
    checkOutput("single_pulse", 128'(lastPulse), 128'(2'b01));

    // Contention from reset: 0,1 then 0,1 again.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(2'b11, {$urandom, $urandom});
    serve(2, {$urandom, $urandom}, 1'b0, 2'b00, 1'b0);
    checkOutput("cont_g0a", 128'(lastPulse), 128'(2'b01));
    serve(1, {$urandom, $urandom}, 1'b0, 2'b11, 1'b0);
    checkOutput("cont_g1a", 128'(lastPulse), 128'(2'b10));
    serve(0, {$urandom, $urandom}, 1'b0, 2'b00, 1'b0);
    checkOutput("cont_g0b", 128'(lastPulse), 128'(2'b01));
    serve(2, {$urandom, $urandom}, 1'b0, 2'b00, 1'b0);
    checkOutput("cont_g1b", 128'(lastPulse), 128'(2'b10));
    checkStats("cont");

    // Starvation: requester 0 re-asks immediately, requester 1 still served.
    applyStimulus(2'b11, {$urandom, $urandom});
    serve(1, {$urandom, $urandom}, 1'b0, 2'b01, 1'b0);
    serve(1, {$urandom, $urandom}, 1'b0, 2'b00, 1'b0);
    checkOutput("starve_g1", 128'(lastPulse), 128'(2'b10));
    serve(0, {$urandom, $urandom}, 1'b0, 2'b00, 1'b0);

    // Abort on requester 1, then normal arbitration.
    applyStimulus(2'b10, {$urandom, $urandom});
    serve(3, {$urandom, $urandom}, 1'b1, 2'b00, 1'b0);
    checkOutput("abort_pulse", 128'(lastPulse), 128'(2'b00));
    applyStimulus(2'b01, {$urandom, $urandom});
    serve(1, {$urandom, $urandom}, 1'b0, 2'b00, 1'b0);
    checkOutput("after_abort", 128'(lastPulse), 128'(2'b01));

    // Stray memory completions while idle start nothing.
    mem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("idle_valid", 128'(mem_req_valid), 128'(0));
      checkOutput("idle_ready", 128'(req_ready), 128'(0));
    end
    mem_req_ready = 1'b0;

    // Reset while BUSY drops the transaction; arbitration restarts at 0.
    applyStimulus(2'b10, {$urandom, $urandom});
    g = pickModel(req_valid);
    rrPtr = (g + 1) % N;
    curG  = g;
    tick();
    checkOutput("midrst_busy", 128'(mem_req_valid), 128'(1));
    reset = 1'b1;
    tick();
    curG = -1;
    req_valid = '0;
    checkOutput("midrst_valid", 128'(mem_req_valid), 128'(0));
    checkOutput("midrst_ready", 128'(req_ready), 128'(0));
    checkOutput("midrst_addr", 128'(mem_req_addr), 128'(0));
    checkOutput("midrst_rdata", 128'(req_rdata), 128'(0));
    reset = 1'b0;
    tick();
    checkOutput("midrst_nopulse", 128'(req_ready), 128'(0));
    applyStimulus(2'b11, {$urandom, $urandom});
    serve(1, {$urandom, $urandom}, 1'b0, 2'b00, 1'b0);
    checkOutput("midrst_first", 128'(lastPulse), 128'(2'b01));
    serve(0, {$urandom, $urandom}, 1'b0, 2'b00, 1'b0);

    // Randomized traffic with churn on non-granted requesters.
    for (int i = 0; i < 24; i++) begin
      if (req_valid == '0) req_valid = N'($urandom_range(1, (1 << N) - 1));
      req_addr = {$urandom, $urandom};
      serve($urandom_range(0, 4), {$urandom, $urandom}, ($urandom_range(0, 4) == 0),
            N'($urandom), 1'b1);
    end
    guard = 0;
    while (req_valid != '0 && guard < 8) begin
      serve(1, {$urandom, $urandom}, 1'b0, 2'b00, 1'b0);
      guard++;
    end
    checkOutput("drain_done", 128'(req_valid), 128'(0));
    checkStats("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
